// File: rtl/cpu16_isa_pkg.sv
// Shared ISA constants for the 16-bit CPU fetch path: widths, opcodes, op-field slice and fetch FSM states.
package cpu16_isa_pkg;

  localparam int unsigned ISA_AW = 5;
  localparam int unsigned ISA_IW = 16;

  localparam int unsigned OP_HI = 15;
  localparam int unsigned OP_LO = 12;

  localparam logic [3:0] OPC_JMP  = 4'hC;
  localparam logic [3:0] OPC_BZ   = 4'hD;
  localparam logic [3:0] OPC_CALL = 4'hE;
  localparam logic [3:0] OPC_RET  = 4'hF;

  typedef enum logic {
    RUN,
    SQUASH
  } fetch_state_e;

endpackage

// File: rtl/instr_fetch_branch_decode.sv
// Combinational branch resolution on the instruction register; CALL/RET decode exists only under FETCH_CALL_RET_EN.
module branch_decode
  import cpu16_isa_pkg::*;
#(
  parameter int unsigned AW = ISA_AW,
  parameter int unsigned IW = ISA_IW
) (
  input  logic [IW-1:0] ir,
  input  logic          ir_valid,
  input  logic          zero_flag,
  input  logic [AW-1:0] link,
  output logic          take,
  output logic [AW-1:0] target
);

  logic [3:0] op;
  assign op = ir[OP_HI:OP_LO];

  // target is forced to zero whenever the branch is not taken
  always_comb begin
    take   = 1'b0;
    target = '0;
    if (ir_valid) begin
      case (op)
        OPC_JMP: begin
          take   = 1'b1;
          target = ir[AW-1:0];
        end
        OPC_BZ: begin
          take   = zero_flag;
          target = zero_flag ? ir[AW-1:0] : '0;
        end
`ifdef FETCH_CALL_RET_EN
        OPC_CALL: begin
          take   = 1'b1;
          target = ir[AW-1:0];
        end
        OPC_RET: begin
          take   = 1'b1;
          target = link;
        end
`endif
        default: begin
          take   = 1'b0;
          target = '0;
        end
      endcase
    end
  end

  logic unused_bits;
`ifdef FETCH_CALL_RET_EN
  assign unused_bits = ^ir[OP_LO-1:AW];
`else
  assign unused_bits = ^{link, ir[OP_LO-1:AW]};
`endif

endmodule

// File: rtl/instr_fetch.sv
// Fetch stage: captures ROM word into IR, resolves branches and squashes one wrong-path slot.
// Optional CALL/RET with a single-entry link register is enabled by FETCH_CALL_RET_EN.
module instr_fetch
  import cpu16_isa_pkg::*;
#(
  parameter int unsigned AW = ISA_AW,
  parameter int unsigned IW = ISA_IW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [AW-1:0] pc_adr,
  output logic [AW-1:0] rom_adr,
  input  logic [IW-1:0] rom_data,
  input  logic          zero_flag,
  output logic          pob,
  output logic [AW-1:0] buscin,
  output logic [IW-1:0] ir,
  output logic [AW-1:0] ir_pc,
  output logic          ir_valid
);

  fetch_state_e  state;
  logic          take;
  logic [AW-1:0] target;
  logic [AW-1:0] link;

  assign rom_adr = pc_adr;
  assign pob     = take;
  assign buscin  = target;

  branch_decode #(
    .AW(AW),
    .IW(IW)
  ) u_branch_decode (
    .ir        (ir),
    .ir_valid  (ir_valid),
    .zero_flag (zero_flag),
    .link      (link),
    .take      (take),
    .target    (target)
  );

`ifdef FETCH_CALL_RET_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      link <= '0;
    end else if (take && (ir[OP_HI:OP_LO] == OPC_CALL)) begin
      link <= ir_pc + AW'(1);
    end
  end
`else
  assign link = '0;
`endif

  // The word fetched on the redirect edge is the fall-through, so it is invalidated there.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ir       <= '0;
      ir_pc    <= '0;
      ir_valid <= 1'b0;
      state    <= RUN;
    end else begin
      ir    <= rom_data;
      ir_pc <= pc_adr;
      case (state)
        RUN: begin
          if (take) begin
            ir_valid <= 1'b0;
            state    <= SQUASH;
          end else begin
            ir_valid <= 1'b1;
          end
        end
        SQUASH: begin
          ir_valid <= 1'b1;
          state    <= RUN;
        end
        default: begin
          ir_valid <= 1'b0;
          state    <= RUN;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: PC and ROM environment plus a cycle-level program-flow reference model.
module tb_instr_fetch;

  localparam int AW = 5;
  localparam int IW = 16;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [AW-1:0] pc_adr;
  logic [AW-1:0] rom_adr;
  logic [IW-1:0] rom_data;
  logic          zero_flag = 1'b0;
  logic          pob;
  logic [AW-1:0] buscin;
  logic [IW-1:0] ir;
  logic [AW-1:0] ir_pc;
  logic          ir_valid;

  logic [IW-1:0] rom [32];

  int tests = 0;
  int fails = 0;
  int zf_mode = 0;

  // reference model state
  logic [AW-1:0] m_pc, m_ir_pc, m_link;
  logic [IW-1:0] m_ir;
  logic          m_valid;

  always #5 clk = ~clk;

  assign rom_data = rom[rom_adr];

  always @(posedge clk or posedge reset) begin
    if (reset) pc_adr <= '0;
    else       pc_adr <= pob ? buscin : pc_adr + 5'd1;
  end

  instr_fetch #(
    .AW(AW),
    .IW(IW)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .pc_adr    (pc_adr),
    .rom_adr   (rom_adr),
    .rom_data  (rom_data),
    .zero_flag (zero_flag),
    .pob       (pob),
    .buscin    (buscin),
    .ir        (ir),
    .ir_pc     (ir_pc),
    .ir_valid  (ir_valid)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  function automatic bit m_taken(input logic z);
    logic [3:0] op;
    op = m_ir[15:12];
    if (!m_valid) return 1'b0;
    if (op == 4'hC) return 1'b1;
    if (op == 4'hD) return z;
`ifdef FETCH_CALL_RET_EN
    if (op == 4'hE || op == 4'hF) return 1'b1;
`endif
    return 1'b0;
  endfunction

  function automatic logic [AW-1:0] m_target();
`ifdef FETCH_CALL_RET_EN
    if (m_ir[15:12] == 4'hF) return m_link;
`endif
    return m_ir[AW-1:0];
  endfunction

  task automatic check_outputs();
    bit t;
    t = m_taken(zero_flag);
    check("ir",       32'(ir),       32'(m_ir));
    check("ir_pc",    32'(ir_pc),    32'(m_ir_pc));
    check("ir_valid", 32'(ir_valid), 32'(m_valid));
    check("pob",      32'(pob),      32'(t));
    check("buscin",   32'(buscin),   t ? 32'(m_target()) : 32'd0);
    check("rom_adr",  32'(rom_adr),  32'(m_pc));
  endtask

  task automatic drive_zf();
    case (zf_mode)
      0:       zero_flag = 1'b0;
      1:       zero_flag = 1'b1;
      default: zero_flag = 1'($urandom % 2);
    endcase
  endtask

  // Called right after a falling edge; reset is checked before any rising edge arrives.
  task automatic do_reset();
    reset   = 1'b1;
    m_pc    = '0;
    m_ir_pc = '0;
    m_link  = '0;
    m_ir    = '0;
    m_valid = 1'b0;
    drive_zf();
    #2;
    check_outputs();
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic step();
    bit            t;
    logic [AW-1:0] tgt;
    @(posedge clk);
    t   = m_taken(zero_flag);
    tgt = m_target();
`ifdef FETCH_CALL_RET_EN
    if (t && m_ir[15:12] == 4'hE) m_link = m_ir_pc + 5'd1;
`endif
    m_ir    = rom[m_pc];
    m_ir_pc = m_pc;
    m_valid = !t;
    m_pc    = t ? tgt : m_pc + 5'd1;
    #1;
    drive_zf();
    @(negedge clk);
    check_outputs();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic fill_linear();
    for (int i = 0; i < 32; i++) rom[i] = 16'h1000 + 16'(i);
  endtask

  initial begin
    fill_linear();
    @(negedge clk);

    // straight-line code
    zf_mode = 0;
    do_reset();
    run(6);

    // unconditional jump at address 2 to 10
    rom[2] = 16'hC00A;
    do_reset();
    run(8);

    // BZ not taken, then taken
    fill_linear();
    rom[1] = 16'hD005;
    zf_mode = 0;
    do_reset();
    run(6);
    zf_mode = 1;
    do_reset();
    run(6);

    // reset asserted during the squash slot
    fill_linear();
    rom[2] = 16'hC00A;
    zf_mode = 0;
    do_reset();
    run(4);
    check("squash_slot", 32'(ir_valid), 32'd0);
    do_reset();
    run(4);

    // address wrap with straight-line code, then JMP at 31
    fill_linear();
    do_reset();
    run(35);
    rom[31] = 16'hC003;
    do_reset();
    run(36);

    // CALL 20 at 4, RET at 20 (ordinary opcodes when the feature is off)
    fill_linear();
    rom[4]  = 16'hE014;
    rom[20] = 16'hF000;
    do_reset();
    run(30);

    // randomized programs with random zero flag
    zf_mode = 2;
    for (int k = 0; k < 4; k++) begin
      for (int i = 0; i < 32; i++) begin
        logic [3:0] op;
        case ($urandom % 7)
          0:       op = 4'hC;
          1:       op = 4'hD;
          2:       op = 4'hE;
          3:       op = 4'hF;
          default: op = 4'($urandom);
        endcase
        rom[i] = {op, 12'($urandom)};
      end
      do_reset();
      run(150);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
